modport_dut: RTL and testbench

Six-channel MOSFET figure-of-merit calculator with a sort-and-select stage. Each cycle that `valid` is asserted, it evaluates the drain current or transconductance of six square-law NMOS devices. It ranks the six results, keeps either the three largest or the three smallest, and registers a weighted sum on `out_n`. The block sits behind the `mem_intf` driver/monitor interface as the design under test. All of its ports are sampled and driven through that interface's clocking blocks.

---
 rtl/modport_dut.sv | 125 ++++++++++++
 tb/tb_modport_dut.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/modport_dut.sv
// Six-channel square-law NMOS figure-of-merit calculator with sort-and-select.
// Evaluates I or gm per device, ranks them, and registers a weighted sum of three.
module modport_dut (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] W_0,
   input  logic [2:0] W_1,
   input  logic [2:0] W_2,
   input  logic [2:0] W_3,
   input  logic [2:0] W_4,
   input  logic [2:0] W_5,
   input  logic [2:0] V_GS_0,
   input  logic [2:0] V_GS_1,
   input  logic [2:0] V_GS_2,
   input  logic [2:0] V_GS_3,
   input  logic [2:0] V_GS_4,
   input  logic [2:0] V_GS_5,
   input  logic [2:0] V_DS_0,
   input  logic [2:0] V_DS_1,
   input  logic [2:0] V_DS_2,
   input  logic [2:0] V_DS_3,
   input  logic [2:0] V_DS_4,
   input  logic [2:0] V_DS_5,
   input  logic [1:0] mode,
   input  logic       valid,
   output logic [9:0] out_n
);

   localparam int unsigned N_DEV  = 6;
   localparam int unsigned IN_W   = 3;
   localparam int unsigned VAL_W  = 7;
   localparam int unsigned PROD_W = 9;
   localparam int unsigned OUT_W  = 10;

   logic [IN_W-1:0]  w_arr   [N_DEV];
   logic [IN_W-1:0]  vgs_arr [N_DEV];
   logic [IN_W-1:0]  vds_arr [N_DEV];
   logic [VAL_W-1:0] n_val   [N_DEV];
   logic [VAL_W-1:0] srt     [N_DEV];
   logic [VAL_W-1:0] swap_tmp;
   logic [VAL_W-1:0] sel_a;
   logic [VAL_W-1:0] sel_b;
   logic [VAL_W-1:0] sel_c;
   logic [OUT_W-1:0] result_c;

   // Gather the flat device ports into indexable arrays.
   always_comb begin
      w_arr[0]   = W_0;    w_arr[1]   = W_1;    w_arr[2]   = W_2;
      w_arr[3]   = W_3;    w_arr[4]   = W_4;    w_arr[5]   = W_5;
      vgs_arr[0] = V_GS_0; vgs_arr[1] = V_GS_1; vgs_arr[2] = V_GS_2;
      vgs_arr[3] = V_GS_3; vgs_arr[4] = V_GS_4; vgs_arr[5] = V_GS_5;
      vds_arr[0] = V_DS_0; vds_arr[1] = V_DS_1; vds_arr[2] = V_DS_2;
      vds_arr[3] = V_DS_3; vds_arr[4] = V_DS_4; vds_arr[5] = V_DS_5;
   end

   // Square-law device: sel_i=1 gives drain current, 0 gives transconductance.
   function automatic logic [VAL_W-1:0] fom(
      input logic [IN_W-1:0] w,
      input logic [IN_W-1:0] vgs,
      input logic [IN_W-1:0] vds,
      input logic            sel_i
   );
      logic [IN_W-1:0]   vov;
      logic [PROD_W-1:0] term;
      logic [PROD_W-1:0] prod;
      vov  = (vgs == 3'd0) ? 3'd0 : vgs - 3'd1;
      term = '0;
      if (vov != 3'd0) begin
         if (vov > vds) begin
            // Triode: the subtraction cannot underflow because vov > vds.
            if (sel_i)
               term = PROD_W'(2) * PROD_W'(vov) * PROD_W'(vds) - PROD_W'(vds) * PROD_W'(vds);
            else
               term = PROD_W'(2) * PROD_W'(vds);
         end else begin
            if (sel_i)
               term = PROD_W'(vov) * PROD_W'(vov);
            else
               term = PROD_W'(2) * PROD_W'(vov);
         end
      end
      prod = PROD_W'(w) * term;
      return VAL_W'(prod / PROD_W'(3));
   endfunction

   always_comb begin
      for (int unsigned k = 0; k < N_DEV; k++)
         n_val[k] = fom(w_arr[k], vgs_arr[k], vds_arr[k], mode[0]);
   end

   // Odd-even transposition sort, descending; N_DEV stages fully sort N_DEV values.
   always_comb begin
      swap_tmp = '0;
      srt      = n_val;
      for (int unsigned st = 0; st < N_DEV; st++) begin
         for (int unsigned i = st % 2; i + 1 < N_DEV; i += 2) begin
            if (srt[i] < srt[i+1]) begin
               swap_tmp = srt[i];
               srt[i]   = srt[i+1];
               srt[i+1] = swap_tmp;
            end
         end
      end
   end

   // Pick the top or bottom three and form the weighted result.
   always_comb begin
      sel_a = mode[1] ? srt[0] : srt[3];
      sel_b = mode[1] ? srt[1] : srt[4];
      sel_c = mode[1] ? srt[2] : srt[5];
      if (mode[0])
         result_c = OUT_W'(3) * OUT_W'(sel_a) + OUT_W'(4) * OUT_W'(sel_b)
                  + OUT_W'(5) * OUT_W'(sel_c);
      else
         result_c = OUT_W'(sel_a) + OUT_W'(sel_b) + OUT_W'(sel_c);
   end

   always_ff @(posedge clk) begin
      if (reset)
         out_n <= '0;
      else if (valid)
         out_n <= result_c;
   end

endmodule

// File: tb/tb_modport_dut.sv
// Bench for modport_dut: directed cases from the device equations plus a
// randomized stream checked against an integer reference model.
module tb_modport_dut;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] w   [6];
   logic [2:0] vgs [6];
   logic [2:0] vds [6];
   logic [1:0] mode;
   logic       valid;
   logic [9:0] out_n;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   modport_dut dut (
      .clk(clk), .reset(reset),
      .W_0(w[0]), .W_1(w[1]), .W_2(w[2]), .W_3(w[3]), .W_4(w[4]), .W_5(w[5]),
      .V_GS_0(vgs[0]), .V_GS_1(vgs[1]), .V_GS_2(vgs[2]),
      .V_GS_3(vgs[3]), .V_GS_4(vgs[4]), .V_GS_5(vgs[5]),
      .V_DS_0(vds[0]), .V_DS_1(vds[1]), .V_DS_2(vds[2]),
      .V_DS_3(vds[3]), .V_DS_4(vds[4]), .V_DS_5(vds[5]),
      .mode(mode), .valid(valid), .out_n(out_n)
   );

   // Reference: evaluate every device, sort the list, pick three, weight them.
   function automatic int model(input logic [1:0] md);
      int q[$];
      int wi, gs, ds, vov, cur, gm, base, a, b, c;
      for (int k = 0; k < 6; k++) begin
         wi  = int'(w[k]);
         gs  = int'(vgs[k]);
         ds  = int'(vds[k]);
         vov = (gs == 0) ? 0 : gs - 1;
         if (vov == 0) begin
            cur = 0; gm = 0;
         end else if (vov > ds) begin
            cur = wi * (2 * vov * ds - ds * ds) / 3;
            gm  = 2 * wi * ds / 3;
         end else begin
            cur = wi * vov * vov / 3;
            gm  = 2 * wi * vov / 3;
         end
         q.push_back(md[0] ? cur : gm);
      end
      q.rsort();
      base = md[1] ? 0 : 3;
      a = q[base]; b = q[base+1]; c = q[base+2];
      return md[0] ? (3 * a + 4 * b + 5 * c) : (a + b + c);
   endfunction

   task automatic set_all(input int wv, input int gsv, input int dsv);
      for (int k = 0; k < 6; k++) begin
         w[k] = 3'(wv); vgs[k] = 3'(gsv); vds[k] = 3'(dsv);
      end
   endtask

   task automatic randomize_inputs();
      for (int k = 0; k < 6; k++) begin
         w[k]   = 3'($urandom_range(0, 7));
         vgs[k] = 3'($urandom_range(0, 7));
         vds[k] = 3'($urandom_range(0, 7));
         // Bias toward the saturation boundary Vov == V_DS.
         if (vgs[k] != 3'd0 && $urandom_range(0, 3) == 0)
            vds[k] = vgs[k] - 3'd1;
      end
      mode = 2'($urandom_range(0, 3));
   endtask

   task automatic clock_check(input string tag, input int exp);
      logic [9:0] exp_v;
      exp_v = 10'(exp);
      @(posedge clk);
      #1;
      n_cmp++;
      assert (out_n === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, out_n, exp_v);
      end
   endtask

   int exp_reg;

   initial begin
      reset = 1'b1;
      valid = 1'b1;
      randomize_inputs();
      #1;
      for (int i = 0; i < 3; i++) begin
         clock_check("reset_hold", 0);
         randomize_inputs();
      end

      reset = 1'b0;
      set_all(1, 3, 3);
      mode = 2'd3; clock_check("uniform_m3", 12);
      mode = 2'd1; clock_check("uniform_m1", 12);
      mode = 2'd2; clock_check("uniform_m2", 3);
      mode = 2'd0; clock_check("uniform_m0", 3);

      for (int k = 0; k < 6; k++) begin
         w[k] = 3'(k + 1); vgs[k] = 3'd3; vds[k] = 3'd3;
      end
      mode = 2'd3; clock_check("ramp_m3", 73);
      mode = 2'd1; clock_check("ramp_m1", 25);
      mode = 2'd2; clock_check("ramp_m2", 19);
      mode = 2'd0; clock_check("ramp_m0", 7);

      set_all(0, 7, 7);
      w[0] = 3'd7;
      mode = 2'd3; clock_check("single_m3", 252);
      mode = 2'd1; clock_check("single_m1", 0);
      mode = 2'd2; clock_check("single_m2", 28);

      set_all(3, 7, 2);
      mode = 2'd3; clock_check("triode_m3", 240);
      mode = 2'd2; clock_check("triode_m2", 12);

      valid = 1'b0;
      randomize_inputs();
      clock_check("hold_1", 12);
      randomize_inputs();
      clock_check("hold_2", 12);

      exp_reg = 12;
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         reset = ($urandom_range(0, 39) == 0);
         valid = ($urandom_range(0, 3) != 0);
         if (reset)
            exp_reg = 0;
         else if (valid)
            exp_reg = model(mode);
         clock_check("random", exp_reg);
      end

      reset = 1'b1;
      valid = 1'b1;
      set_all(7, 7, 7);
      mode = 2'd3;
      clock_check("reset_mid", 0);
      reset = 1'b0;
      valid = 1'b0;
      clock_check("reset_after", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
